// File: rtl/dac8531_frame_rx_if.sv
// dac8531_frame_rx_if
// Groups the DAC8531 serial pins and the decoded-frame outputs into one bundle.
//   master : drives SYNC/SCLK/DIN, observes the decoded outputs (serial source / bench)
//   slave  : receives SYNC/SCLK/DIN, drives the decoded outputs (the receiver)
// Signals:
//   SYNC      frame select, active low
//   SCLK      serial clock, data valid on its falling edge
//   DIN       serial data, MSB (DB23) first
//   data      D15..D0 of the last complete frame
//   pd        PD1,PD0 of the last complete frame
//   hdr       DB23..DB18 of the last complete frame
//   valid     one-cycle pulse when data/pd/hdr update
//   frame_err one-cycle pulse on an aborted frame
//   frame_cnt count of good frames, wraps
interface dac8531_frame_rx_if;
  logic        SYNC;
  logic        SCLK;
  logic        DIN;
  logic [15:0] data;
  logic [1:0]  pd;
  logic [5:0]  hdr;
  logic        valid;
  logic        frame_err;
  logic [15:0] frame_cnt;

  modport master (
    output SYNC, SCLK, DIN,
    input  data, pd, hdr, valid, frame_err, frame_cnt
  );

  modport slave (
    input  SYNC, SCLK, DIN,
    output data, pd, hdr, valid, frame_err, frame_cnt
  );
endinterface

// File: rtl/dac8531_frame_rx.sv
// dac8531_frame_rx
// Oversampling receiver for DAC8531 24-bit write frames. SYNC, SCLK and DIN
// are synchronized into clk_100M, SCLK falling edges are detected on the
// synchronized copy, and a 3-state FSM assembles the frame.
// Ports:
//   clk_100M  sole clock (oversamples the serial pins)
//   rst       asynchronous, active-high reset
//   bus       dac8531_frame_rx_if.slave (serial inputs, decoded outputs)
module dac8531_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 24
) (
  input  logic               clk_100M,
  input  logic               rst,
  dac8531_frame_rx_if.slave  bus
);

  // Depths below 2 are clamped up so metastability protection is never lost.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    DONE_WAIT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SS-1:0]           sync_chain_q, sync_chain_d;
  logic [SS-1:0]           sclk_chain_q, sclk_chain_d;
  logic [SS-1:0]           din_chain_q, din_chain_d;
  logic                    sclk_prev_q, sclk_prev_d;
  logic [FRAME_BITS-1:0]   sr_q, sr_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [15:0]             data_q, data_d;
  logic [1:0]              pd_q, pd_d;
  logic [5:0]              hdr_q, hdr_d;
  logic                    valid_q, valid_d;
  logic                    frame_err_q, frame_err_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;

  logic                    sync_s, sclk_s, din_s, sclk_fall;
  logic [FRAME_BITS-1:0]   sr_shift;

  assign sync_s    = sync_chain_q[SS-1];
  assign sclk_s    = sclk_chain_q[SS-1];
  assign din_s     = din_chain_q[SS-1];
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  // Register contents as they will be once the current bit is shifted in;
  // the 24th edge loads the outputs straight from this so valid lands one
  // cycle after the edge.
  assign sr_shift  = {sr_q[FRAME_BITS-2:0], din_s};

  always_comb begin
    sync_chain_d = {sync_chain_q[SS-2:0], bus.SYNC};
    sclk_chain_d = {sclk_chain_q[SS-2:0], bus.SCLK};
    din_chain_d  = {din_chain_q[SS-2:0], bus.DIN};
    sclk_prev_d  = sclk_s;

    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_q;
    pd_d         = pd_q;
    hdr_d        = hdr_q;
    frame_cnt_d  = frame_cnt_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Any SCLK edge seen while entering SHIFT is deliberately dropped.
        if (!sync_s) begin
          state_d   = SHIFT;
          sr_d      = '0;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        // The edge is checked before SYNC so a final edge coincident with
        // SYNC rising still completes the frame.
        if (sclk_fall) begin
          sr_d      = sr_shift;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == LAST_CNT) begin
            state_d     = DONE_WAIT;
            data_d      = sr_shift[15:0];
            pd_d        = sr_shift[17:16];
            hdr_d       = sr_shift[23:18];
            valid_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end else if (sync_s) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != '0);
        end
      end
      DONE_WAIT: begin
        if (sync_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      sync_chain_q <= '1;
      sclk_chain_q <= '0;
      din_chain_q  <= '0;
      sclk_prev_q  <= 1'b0;
      state_q      <= IDLE;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      pd_q         <= '0;
      hdr_q        <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      sync_chain_q <= sync_chain_d;
      sclk_chain_q <= sclk_chain_d;
      din_chain_q  <= din_chain_d;
      sclk_prev_q  <= sclk_prev_d;
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      data_q       <= data_d;
      pd_q         <= pd_d;
      hdr_q        <= hdr_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.pd        = pd_q;
  assign bus.hdr       = hdr_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dac8531_frame_rx.sv
// tb_dac8531_frame_rx
// Directed bench for dac8531_frame_rx: sends DAC8531 frames at 10 MHz SCLK
// and compares decoded outputs against hand-computed constants.
module tb_dac8531_frame_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;

  dac8531_frame_rx_if bus_if ();

  dac8531_frame_rx #(.SYNC_STAGES(2), .FRAME_BITS(24)) dut (
    .clk_100M (clk),
    .rst      (rst),
    .bus      (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int vcount   = 0;
  int ecount   = 0;
  int both     = 0;

  always @(negedge clk) begin
    if (bus_if.valid)                     vcount++;
    if (bus_if.frame_err)                 ecount++;
    if (bus_if.valid && bus_if.frame_err) both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [15:0] e_data, input logic [1:0] e_pd,
                             input logic [5:0] e_hdr, input logic [15:0] e_cnt);
    chk({tag, ".data"}, 32'(bus_if.data), 32'(e_data));
    chk({tag, ".pd"},   32'(bus_if.pd),   32'(e_pd));
    chk({tag, ".hdr"},  32'(bus_if.hdr),  32'(e_hdr));
    chk({tag, ".cnt"},  32'(bus_if.frame_cnt), 32'(e_cnt));
  endtask

  // Sends nedges SCLK falling edges with SYNC low; bits beyond 24 are 1.
  // sync_on_last raises SYNC at the same instant as the final falling edge.
  task automatic send_frame(input logic [23:0] w, input int nedges, input bit sync_on_last);
    bus_if.SYNC = 1'b0;
    #100;
    for (int i = 0; i < nedges; i++) begin
      bus_if.SCLK = 1'b1;
      bus_if.DIN  = (i < 24) ? w[23 - i] : 1'b1;
      #50;
      bus_if.SCLK = 1'b0;
      if (sync_on_last && i == nedges - 1) bus_if.SYNC = 1'b1;
      #50;
    end
    bus_if.SYNC = 1'b1;
    #200;
  endtask

  int v0, e0;

  initial begin
    bus_if.SYNC = 1'b1;
    bus_if.SCLK = 1'b0;
    bus_if.DIN  = 1'b0;

    // Asynchronous reset: checked before any clock edge arrives.
    #10 rst = 1'b1;
    #2;
    chk_outputs("reset", 16'h0000, 2'b00, 6'h00, 16'h0000);
    chk("reset.valid", 32'(bus_if.valid), 32'h0);
    chk("reset.err",   32'(bus_if.frame_err), 32'h0);
    #18 rst = 1'b0;
    #100;

    // hdr=0 pd=00 data=0x1234
    v0 = vcount; e0 = ecount;
    send_frame(24'h001234, 24, 1'b0);
    chk("f1.vld", 32'(vcount - v0), 32'd1);
    chk("f1.err", 32'(ecount - e0), 32'd0);
    chk_outputs("f1", 16'h1234, 2'b00, 6'h00, 16'd1);

    // hdr=0x2A pd=11 data=0xFFFF -> word 0xABFFFF
    v0 = vcount; e0 = ecount;
    send_frame(24'hABFFFF, 24, 1'b0);
    chk("f2.vld", 32'(vcount - v0), 32'd1);
    chk_outputs("f2", 16'hFFFF, 2'b11, 6'h2A, 16'd2);

    // Abort after 10 bits: one error pulse, outputs hold.
    v0 = vcount; e0 = ecount;
    send_frame(24'h3C5A5A, 10, 1'b0);
    chk("abort.vld", 32'(vcount - v0), 32'd0);
    chk("abort.err", 32'(ecount - e0), 32'd1);
    chk_outputs("abort", 16'hFFFF, 2'b11, 6'h2A, 16'd2);

    v0 = vcount; e0 = ecount;
    send_frame(24'h0000FF, 24, 1'b0);
    chk("f3.vld", 32'(vcount - v0), 32'd1);
    chk("f3.err", 32'(ecount - e0), 32'd0);
    chk_outputs("f3", 16'h00FF, 2'b00, 6'h00, 16'd3);

    // SYNC low then high with no SCLK edges: silent return to idle.
    v0 = vcount; e0 = ecount;
    send_frame(24'h000000, 0, 1'b0);
    chk("empty.vld", 32'(vcount - v0), 32'd0);
    chk("empty.err", 32'(ecount - e0), 32'd0);
    chk("empty.cnt", 32'(bus_if.frame_cnt), 32'd3);

    // 30 edges: extra six ignored.
    v0 = vcount; e0 = ecount;
    send_frame(24'h008001, 30, 1'b0);
    chk("long.vld", 32'(vcount - v0), 32'd1);
    chk("long.err", 32'(ecount - e0), 32'd0);
    chk_outputs("long", 16'h8001, 2'b00, 6'h00, 16'd4);

    // Reset after 12 bits: everything cleared, no error pulse.
    v0 = vcount; e0 = ecount;
    bus_if.SYNC = 1'b0;
    #100;
    for (int i = 0; i < 12; i++) begin
      bus_if.SCLK = 1'b1;
      bus_if.DIN  = i[0];
      #50;
      bus_if.SCLK = 1'b0;
      #50;
    end
    rst = 1'b1;
    bus_if.SYNC = 1'b1;
    #2;
    chk_outputs("midrst", 16'h0000, 2'b00, 6'h00, 16'h0000);
    #28 rst = 1'b0;
    #100;
    chk("midrst.err", 32'(ecount - e0), 32'd0);
    chk("midrst.vld", 32'(vcount - v0), 32'd0);

    v0 = vcount; e0 = ecount;
    send_frame(24'h005A5A, 24, 1'b0);
    chk("f5.vld", 32'(vcount - v0), 32'd1);
    chk_outputs("f5", 16'h5A5A, 2'b00, 6'h00, 16'd1);

    // Final edge coincident with SYNC rising: word 0xD6C3C3 -> hdr 0x35 pd 10.
    v0 = vcount; e0 = ecount;
    send_frame(24'hD6C3C3, 24, 1'b1);
    chk("prio.vld", 32'(vcount - v0), 32'd1);
    chk("prio.err", 32'(ecount - e0), 32'd0);
    chk_outputs("prio", 16'hC3C3, 2'b10, 6'h35, 16'd2);

    chk("overlap", 32'(both), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/dac8531_frame_rx.md
DAC8531_FRAME_RX -- requirements
Module: dac8531_frame_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets the synchronizer depth applied to SYNC, SCLK and DIN, with a minimum of 2.
REQ-002 Parameter FRAME_BITS, default 24, sets the number of bits in one DAC8531 write frame; the block is only required to work at 24.
REQ-003 clk_100M  input  1  sole clock, oversamples the serial pins; reset is asynchronous and active-high.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 SYNC  input  1  frame select, active low, asynchronous to clk_100M.
REQ-006 SCLK  input  1  serial clock; data is valid on its falling edge; frequency at most clk_100M/4.
REQ-007 DIN  input  1  serial data, MSB (DB23) first.
REQ-008 data  output  16  D15..D0 of the last complete frame.
REQ-009 pd  output  2  PD1,PD0 of the last complete frame.
REQ-010 hdr  output  6  DB23..DB18 (don't-care bits) of the last complete frame.
REQ-011 valid  output  1  one-cycle pulse, high when data/pd/hdr update.
REQ-012 frame_err  output  1  one-cycle pulse on an aborted frame.
REQ-013 frame_cnt  output  16  count of good frames, wraps.

Function
REQ-014 SYNC, SCLK and DIN shall each pass through SYNC_STAGES flip-flops before any use; the names sync_s, sclk_s and din_s below refer to these synchronized signals.
REQ-015 A falling edge shall be detected when sclk_s was 1 in the previous cycle and is 0 in the current cycle.
REQ-016 The FSM shall have three states: IDLE, SHIFT and DONE_WAIT; reset shall enter IDLE.
REQ-017 IDLE shall move to SHIFT in the cycle after sync_s is sampled 0, clearing the shift register and setting bit_cnt to 0; an SCLK falling edge detected in that same cycle shall be ignored.
REQ-018 In SHIFT, each detected falling edge shall shift din_s into the LSB of a 24-bit register and increment bit_cnt.
REQ-019 In SHIFT, on the falling edge that makes bit_cnt reach 24, the FSM shall move to DONE_WAIT.
REQ-020 In the cycle after that 24th edge, data shall take sr[15:0], pd shall take sr[17:16], hdr shall take sr[23:18], valid shall pulse, and frame_cnt shall increment.
REQ-021 Frame latency from the internal detection of the 24th edge to valid shall be exactly 1 clk_100M cycle, which gives at most SYNC_STAGES+2 cycles from the pin edge.
REQ-022 In SHIFT, if sync_s is sampled 1 with bit_cnt between 1 and 23, frame_err shall pulse one cycle later, data/pd/hdr/frame_cnt shall hold, and the FSM shall return to IDLE.
REQ-023 In SHIFT, if sync_s is sampled 1 with bit_cnt = 0, the FSM shall return to IDLE without flagging an error.
REQ-024 If the 24th falling edge and sync_s rising are sampled in the same cycle, the edge shall take priority: the frame is good, valid pulses, and there is no frame_err.
REQ-025 In DONE_WAIT, further falling edges shall be ignored, and sync_s = 1 shall return the FSM to IDLE.
REQ-026 A new frame shall require SYNC to go high and then low again.
REQ-027 frame_cnt shall increment modulo 2^16, so 0xFFFF + 1 = 0x0000.
REQ-028 valid and frame_err shall never be high in the same cycle.
REQ-029 Outputs shall change only on clk_100M rising edges.

Reset
REQ-030 rst = 1 shall clear immediately, without waiting for a clock, data, pd, hdr, valid, frame_err, frame_cnt, the shift register, bit_cnt and every synchronizer stage.
REQ-031 In the reset state the SYNC synchronizer stages shall read 1, the SCLK synchronizer stages shall read 0, and the FSM shall be in IDLE.
REQ-032 Reset asserted mid-frame shall discard the partial frame without pulsing frame_err.
REQ-033 After reset release, decoding shall start only with a SYNC low that is sampled after release.

Verification
REQ-034 A 10 MHz SCLK frame of hdr=0, pd=00, data=0x1234 shall produce exactly one valid pulse with data=0x1234, pd=00, hdr=0 and frame_cnt=1.
REQ-035 A frame of hdr=0x2A, pd=11, data=0xFFFF sent after REQ-034 shall produce pd=11, hdr=0x2A, data=0xFFFF and frame_cnt=2.
REQ-036 SYNC raised after 10 bits shall produce one frame_err pulse, no valid, unchanged outputs, and a following frame with data=0x00FF shall decode correctly.
REQ-037 A frame with 30 SCLK falling edges while SYNC is low, data=0x8001, shall produce a single valid pulse with data=0x8001, with the extra edges ignored.
REQ-038 rst pulsed after 12 bits shall clear all outputs to 0 with no frame_err, and the next full frame with data=0x5A5A shall decode with frame_cnt=1.
